// File: rtl/mcp_datapath.sv
// mcp_datapath: multicycle MIPS datapath.
// Holds PC, IR, memory data register, A/B operand latches, ALUOut and the
// 32x32 register file. The controller drives the per-cycle selects and
// enables; this block returns op/funct/zero for decode and branching.
// There is no handshake on this block: every input is sampled on each rising
// clk edge, and adr/zero/op/funct are combinational from current state and
// selects within the same cycle.
module mcp_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcen,
    input  logic        irwrite,
    input  logic        regwrite,
    input  logic        alusrca,
    input  logic        iord,
    input  logic        memtoreg,
    input  logic        regdst,
    input  logic [1:0]  alusrcb,
    input  logic [1:0]  pcsrc,
    input  logic [2:0]  alucontrol,
    input  logic [31:0] readdata,
    output logic [31:0] adr,
    output logic [31:0] writedata,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        zero
);

    // Architectural and inter-cycle state
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_data;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_aluout;
    logic [31:0] r_rf [32];

    // Decode fields and datapath nets
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_wa3;
    logic [31:0] w_wd3;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    logic [31:0] w_signimm;
    logic [31:0] w_signimm_sh;
    logic [31:0] w_jump_target;
    logic [31:0] w_srca;
    logic [31:0] w_srcb;
    logic [31:0] w_aluresult;
    logic [31:0] w_pcnext;

    assign w_rs          = r_instr[25:21];
    assign w_rt          = r_instr[20:16];
    assign w_rd          = r_instr[15:11];
    assign w_wa3         = regdst ? w_rd : w_rt;
    assign w_wd3         = memtoreg ? r_data : r_aluout;
    assign w_signimm     = {{16{r_instr[15]}}, r_instr[15:0]};
    // Shifting drops the top two bits of the extended immediate.
    assign w_signimm_sh  = {w_signimm[29:0], 2'b00};
    assign w_jump_target = {r_pc[31:28], r_instr[25:0], 2'b00};

    // r0 is hardwired to zero on both read ports.
    assign w_rd1 = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
    assign w_rd2 = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];

    assign op        = r_instr[31:26];
    assign funct     = r_instr[5:0];
    assign adr       = iord ? r_aluout : r_pc;
    assign writedata = r_b;
    assign zero      = (w_aluresult == 32'd0);

    // ALU operand selection
    always_comb begin
        w_srca = alusrca ? r_a : r_pc;
        w_srcb = r_b;
        case (alusrcb)
            2'b00:   w_srcb = r_b;
            2'b01:   w_srcb = 32'd4;
            2'b10:   w_srcb = w_signimm;
            default: w_srcb = w_signimm_sh;
        endcase
    end

    // ALU: add/sub/and/or/slt; unused encodings produce zero
    always_comb begin
        w_aluresult = 32'd0;
        case (alucontrol)
            3'b010:  w_aluresult = w_srca + w_srcb;
            3'b110:  w_aluresult = w_srca - w_srcb;
            3'b000:  w_aluresult = w_srca & w_srcb;
            3'b001:  w_aluresult = w_srca | w_srcb;
            3'b111:  w_aluresult = {31'd0, $signed(w_srca) < $signed(w_srcb)};
            default: w_aluresult = 32'd0;
        endcase
    end

    // Next-PC selection; encoding 11 aliases the sequential path
    always_comb begin
        w_pcnext = w_aluresult;
        case (pcsrc)
            2'b01:   w_pcnext = r_aluout;
            2'b10:   w_pcnext = w_jump_target;
            default: w_pcnext = w_aluresult;
        endcase
    end

    // PC register, enabled by pcen
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (pcen) begin
            r_pc <= w_pcnext;
        end
    end

    // Instruction register, enabled by irwrite
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr <= 32'd0;
        end else if (irwrite) begin
            r_instr <= readdata;
        end
    end

    // Unconditional inter-cycle latches: Data, A, B, ALUOut
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data   <= 32'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_aluout <= 32'd0;
        end else begin
            r_data   <= readdata;
            r_a      <= w_rd1;
            r_b      <= w_rd2;
            r_aluout <= w_aluresult;
        end
    end

    // Register file write port; A/B sample the pre-edge value on a same-edge write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= 32'd0;
            end
        end else if (regwrite && (w_wa3 != 5'd0)) begin
            r_rf[w_wa3] <= w_wd3;
        end
    end

endmodule

// File: tb/tb_mcp_datapath.sv
// Testbench for mcp_datapath: directed instruction sequences drive the
// control inputs; expected port values are queued and a negedge monitor
// compares them against the DUT.
module tb_mcp_datapath;

  localparam int S_ADR   = 0;
  localparam int S_WDATA = 1;
  localparam int S_OP    = 2;
  localparam int S_FUNCT = 3;
  localparam int S_ZERO  = 4;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic        pcen;
  logic        irwrite;
  logic        regwrite;
  logic        alusrca;
  logic        iord;
  logic        memtoreg;
  logic        regdst;
  logic [1:0]  alusrcb;
  logic [1:0]  pcsrc;
  logic [2:0]  alucontrol;
  logic [31:0] readdata;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mcp_datapath #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .readdata   (readdata),
    .adr        (adr),
    .writedata  (writedata),
    .op         (op),
    .funct      (funct),
    .zero       (zero)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  // ALU table for operands A = -1, B = 1
  logic [2:0]  alu_ctl_tab [8] = '{3'b111, 3'b010, 3'b110, 3'b000,
                                   3'b001, 3'b011, 3'b100, 3'b101};
  logic [31:0] alu_exp_tab [8] = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0001,
                                   32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

  // Monitor: compares every queued expectation against the current outputs
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [31:0] exp_v;
      logic [31:0] act_v;
      int          sel;
      string       nm;
      exp_v = exp_q.pop_front();
      sel   = sel_q.pop_front();
      nm    = name_q.pop_front();
      case (sel)
        S_ADR:   act_v = adr;
        S_WDATA: act_v = writedata;
        S_OP:    act_v = {26'd0, op};
        S_FUNCT: act_v = {26'd0, funct};
        default: act_v = {31'd0, zero};
      endcase
      n_checks++;
      if (act_v !== exp_v) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", nm, act_v, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int sel, input logic [31:0] v, input string nm);
    exp_q.push_back(v);
    sel_q.push_back(sel);
    name_q.push_back(nm);
  endtask

  // Let the monitor consume queued expectations before inputs change again
  task automatic check_now();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_pc(input logic [31:0] v, input string nm);
    iord = 1'b0;
    expect_out(S_ADR, v, nm);
    check_now();
  endtask

  task automatic chk_aluout(input logic [31:0] v, input string nm);
    iord = 1'b1;
    expect_out(S_ADR, v, nm);
    check_now();
    iord = 1'b0;
  endtask

  task automatic idle();
    pcen = 0; irwrite = 0; regwrite = 0; alusrca = 0; iord = 0;
    memtoreg = 0; regdst = 0; alusrcb = 2'b01; pcsrc = 2'b00; alucontrol = 3'b010;
  endtask

  // Fetch edge (IR load, PC += 4) followed by a decode edge (A/B load)
  task automatic fetch(input logic [31:0] instr);
    readdata = instr; irwrite = 1; pcen = 1; alusrca = 0; alusrcb = 2'b01;
    alucontrol = 3'b010; pcsrc = 2'b00; regwrite = 0; iord = 0;
    step();
    irwrite = 0; pcen = 0;
    step();
  endtask

  // ALUOut <= A + SignImm
  task automatic exec_imm();
    alusrca = 1; alusrcb = 2'b10; alucontrol = 3'b010;
    step();
  endtask

  task automatic wb(input logic dst, input logic m2r);
    regwrite = 1; regdst = dst; memtoreg = m2r;
    step();
    regwrite = 0;
  endtask

  // R-type compare selects: A op B
  task automatic sel_ab(input logic [2:0] ctl);
    alusrca = 1; alusrcb = 2'b00; alucontrol = ctl;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    reset = 1; readdata = 32'h8C0D_1234;
    pcen = 1; irwrite = 1;
    step(); step();
    expect_out(S_ADR, 32'h0, "reset_adr");
    expect_out(S_OP, 32'h0, "reset_op");
    expect_out(S_FUNCT, 32'h0, "reset_funct");
    expect_out(S_WDATA, 32'h0, "reset_writedata");
    check_now();
    chk_aluout(32'h0, "reset_aluout");
    reset = 0; idle();

    // addi r8, r0, 5
    fetch(32'h2008_0005);
    expect_out(S_OP, 32'h08, "fetch_op");
    expect_out(S_FUNCT, 32'h05, "fetch_funct");
    check_now();
    chk_pc(32'h4, "fetch_pc");
    exec_imm();
    expect_out(S_ZERO, 32'h0, "addi_zero");
    check_now();
    chk_aluout(32'h5, "addi_aluout");
    wb(1'b0, 1'b0);
    expect_out(S_WDATA, 32'h0, "read_before_write");
    check_now();
    step();
    expect_out(S_WDATA, 32'h5, "r8_after_write");
    check_now();

    // addi r9, r0, 5 ; beq r8, r9
    fetch(32'h2009_0005);
    chk_pc(32'h8, "fetch2_pc");
    exec_imm(); wb(1'b0, 1'b0);
    fetch(32'h1109_0000);
    sel_ab(3'b110);
    expect_out(S_OP, 32'h04, "beq_op");
    expect_out(S_ZERO, 32'h1, "beq_equal_zero");
    expect_out(S_WDATA, 32'h5, "beq_b");
    check_now();

    // addi r9, r0, 6 ; beq r8, r9
    fetch(32'h2009_0006);
    exec_imm(); wb(1'b0, 1'b0);
    fetch(32'h1109_0000);
    sel_ab(3'b110);
    expect_out(S_ZERO, 32'h0, "beq_unequal_zero");
    check_now();

    // j 0x40
    fetch(32'h0800_0010);
    chk_pc(32'h18, "pre_jump_pc");
    pcsrc = 2'b10; pcen = 1;
    step();
    pcen = 0; pcsrc = 2'b00;
    chk_pc(32'h40, "jump_pc");
    // pcsrc 11 behaves as ALUResult
    alusrca = 0; alusrcb = 2'b01; alucontrol = 3'b010; pcsrc = 2'b11; pcen = 1;
    step();
    pcen = 0; pcsrc = 2'b00;
    chk_pc(32'h44, "pcsrc11_pc");
    // ALUOut <= PC + (SignImm<<2) = 0x44 + 0x40, then PC <= ALUOut
    alusrcb = 2'b11;
    step();
    alusrcb = 2'b01; pcsrc = 2'b01; pcen = 1;
    step();
    pcen = 0; pcsrc = 2'b00;
    chk_pc(32'h84, "pcsrc01_pc");

    // r10 = -1, r11 = 1
    fetch(32'h200A_FFFF);
    exec_imm();
    chk_aluout(32'hFFFF_FFFF, "signext_aluout");
    wb(1'b0, 1'b0);
    fetch(32'h200B_0001);
    exec_imm(); wb(1'b0, 1'b0);

    // slt r12, r10, r11 and the rest of the ALU table
    fetch(32'h014B_602A);
    expect_out(S_OP, 32'h00, "rtype_op");
    expect_out(S_FUNCT, 32'h2A, "rtype_funct");
    check_now();
    for (int i = 0; i < 8; i++) begin
      sel_ab(alu_ctl_tab[i]);
      step();
      chk_aluout(alu_exp_tab[i], $sformatf("alu_ctl_%0d", alu_ctl_tab[i]));
    end
    sel_ab(3'b111);
    step();
    wb(1'b1, 1'b0);

    // slt r12, r11, r10 (swapped)
    fetch(32'h016A_602A);
    sel_ab(3'b111);
    step();
    chk_aluout(32'h0, "slt_swapped");
    expect_out(S_WDATA, 32'hFFFF_FFFF, "swapped_b");
    check_now();

    // r12 written via rd
    fetch(32'h000C_0000);
    expect_out(S_WDATA, 32'h1, "rd_writeback");
    check_now();

    // lw-style writeback of Data into r13
    fetch(32'h8C0D_0000);
    readdata = 32'h1234_5678;
    step();
    wb(1'b0, 1'b1);
    step();
    expect_out(S_WDATA, 32'h1234_5678, "memtoreg_writeback");
    check_now();

    // addi r0, r0, 7 is discarded
    fetch(32'h2000_0007);
    exec_imm();
    chk_aluout(32'h7, "r0_addi_aluout");
    wb(1'b0, 1'b0);
    step();
    expect_out(S_WDATA, 32'h0, "r0_stays_zero");
    check_now();

    // reset mid-instruction with all enables active
    fetch(32'h1109_0000);
    sel_ab(3'b110);
    pcen = 1; irwrite = 1; regwrite = 1; readdata = 32'hFFFF_FFFF; reset = 1;
    step();
    reset = 0; pcen = 0; irwrite = 0; regwrite = 0;
    expect_out(S_OP, 32'h0, "midreset_op");
    expect_out(S_FUNCT, 32'h0, "midreset_funct");
    expect_out(S_WDATA, 32'h0, "midreset_writedata");
    check_now();
    chk_pc(32'h0, "midreset_pc");
    chk_aluout(32'h0, "midreset_aluout");
    step();
    fetch(32'h1109_0000);
    chk_pc(32'h4, "post_reset_fetch_pc");
    sel_ab(3'b110);
    expect_out(S_WDATA, 32'h0, "rf_cleared_r9");
    expect_out(S_ZERO, 32'h1, "rf_cleared_zero");
    check_now();

    // ---------------- report ----------------
    check_now();
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
